// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM scan controller and its channel finder.
package tdm_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    // Lowest set bit of the mask; returns 0 for an empty mask.
    function automatic logic [SEL_W-1:0] lowest_ch(input logic [NUM_CH-1:0] mask);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/next_ch_find.sv
// Combinational channel search: next higher enabled channel, end-of-frame flag and
// lowest enabled channel for a 4-bit enable mask.
module next_ch_find
    import tdm_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [SEL_W-1:0]  cur_i,
    output logic [SEL_W-1:0]  next_o,
    output logic              last_o,
    output logic [SEL_W-1:0]  first_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        next_o = cur_i;
        last_o = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i] && (i > int'(cur_i))) begin
                next_o = SEL_W'(i);
                last_o = 1'b0;
            end
        end
    end

    assign first_o = lowest_ch(mask_i);

endmodule

// File: rtl/tdm_scan_ctrl.sv
// Time-division scan controller: steps a 4:1 mux select over the enabled channels,
// samples the mux output at the end of each dwell and publishes one frame per scan.
module tdm_scan_ctrl
    import tdm_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [NUM_CH-1:0]  en_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_out,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic [NUM_CH-1:0]  sample_data,
    output logic               sample_valid,
    output logic               frame_done
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic [NUM_CH-1:0]  shadow_q, shadow_d;
    logic [NUM_CH-1:0]  data_q, data_d;
    logic               cont_q, cont_d;
    logic               valid_q, valid_d;

    logic [SEL_W-1:0]   next_ch;
    logic [SEL_W-1:0]   first_ch;
    logic               last_ch;
    logic [NUM_CH-1:0]  captured;

    next_ch_find u_next_ch_find (
        .mask_i  (mask_q),
        .cur_i   (sel_q),
        .next_o  (next_ch),
        .last_o  (last_ch),
        .first_o (first_ch)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        dwell_d  = dwell_q;
        mask_d   = mask_q;
        cont_d   = cont_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = 1'b0;

        // Shadow including the current channel's sample, used at the end of a dwell.
        captured        = shadow_q;
        captured[sel_q] = mux_out;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop && (en_mask != '0)) begin
                    state_d  = ST_SCAN;
                    mask_d   = en_mask;
                    dwell_d  = dwell;
                    cont_d   = cont;
                    sel_d    = lowest_ch(en_mask);
                    cnt_d    = dwell;
                    shadow_d = '0;
                end
            end
            ST_SCAN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (!last_ch) begin
                    shadow_d = captured;
                    sel_d    = next_ch;
                    cnt_d    = dwell_q;
                end else begin
                    data_d  = captured;
                    valid_d = 1'b1;
                    if (cont_q) begin
                        sel_d    = first_ch;
                        cnt_d    = dwell_q;
                        shadow_d = '0;
                    end else begin
                        state_d  = ST_IDLE;
                        sel_d    = '0;
                        shadow_d = captured;
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            dwell_q  <= '0;
            mask_q   <= '0;
            cont_q   <= 1'b0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            dwell_q  <= dwell_d;
            mask_q   <= mask_d;
            cont_q   <= cont_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign sel          = sel_q;
    assign busy         = (state_q == ST_SCAN);
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign frame_done   = valid_q;

endmodule

// File: tb/tb_tdm_scan_ctrl.sv
// Directed bench for tdm_scan_ctrl with a behavioural 4:1 mux on the select output.
module tb_tdm_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       cont;
    logic [3:0] en_mask;
    logic [7:0] dwell;
    logic       mux_out;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] sample_data;
    logic       sample_valid;
    logic       frame_done;
    logic [3:0] in_vec;

    int checks = 0;
    int errors = 0;

    tdm_scan_ctrl #(.DWELL_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .cont         (cont),
        .en_mask      (en_mask),
        .dwell        (dwell),
        .mux_out      (mux_out),
        .sel          (sel),
        .busy         (busy),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .frame_done   (frame_done)
    );

    assign mux_out = in_vec[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Inputs change and outputs are observed on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        cont    = 1'b0;
        en_mask = 4'h0;
        dwell   = 8'd0;
        in_vec  = 4'h0;
        step(2);
        rst_n = 1'b1;
        step(1);

        // Reset asserted in the middle of a scan.
        en_mask = 4'hF; dwell = 8'd2; in_vec = 4'hF; start = 1'b1;
        step(1);
        start = 1'b0;
        check("rst_pre_busy", 32'(busy), 32'd1);
        step(4);
        rst_n = 1'b0;
        step(3);
        check("rst_sel",   32'(sel), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_data",  32'(sample_data), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_done",  32'(frame_done), 32'd0);
        rst_n = 1'b1;
        step(3);
        check("rst_rel_busy", 32'(busy), 32'd0);
        check("rst_rel_sel",  32'(sel), 32'd0);
        check("rst_rel_data", 32'(sample_data), 32'd0);

        // Full scan, dwell 2; mask/dwell changes during the scan must be ignored.
        in_vec = 4'b1101; en_mask = 4'hF; dwell = 8'd2; cont = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0; en_mask = 4'h0; dwell = 8'd7;
        for (int k = 0; k < 12; k++) begin
            check("full_sel",   32'(sel), 32'(k / 3));
            check("full_busy",  32'(busy), 32'd1);
            check("full_valid", 32'(sample_valid), 32'd0);
            step(1);
        end
        check("full_valid_end", 32'(sample_valid), 32'd1);
        check("full_done_end",  32'(frame_done), 32'd1);
        check("full_data",      32'(sample_data), 32'hD);
        check("full_busy_end",  32'(busy), 32'd0);
        check("full_sel_end",   32'(sel), 32'd0);
        step(1);
        check("full_valid_pulse", 32'(sample_valid), 32'd0);
        check("full_data_hold",   32'(sample_data), 32'hD);

        // Sparse mask, dwell 0.
        in_vec = 4'hF; en_mask = 4'b1010; dwell = 8'd0; start = 1'b1;
        step(1);
        start = 1'b0;
        check("sparse_sel1",  32'(sel), 32'd1);
        check("sparse_busy",  32'(busy), 32'd1);
        check("sparse_val0",  32'(sample_valid), 32'd0);
        step(1);
        check("sparse_sel3",  32'(sel), 32'd3);
        check("sparse_val1",  32'(sample_valid), 32'd0);
        step(1);
        check("sparse_valid", 32'(sample_valid), 32'd1);
        check("sparse_data",  32'(sample_data), 32'b1010);
        check("sparse_idle",  32'(busy), 32'd0);

        // Continuous mode on a single channel with a toggling input.
        in_vec = 4'b0001; en_mask = 4'b0001; dwell = 8'd1; cont = 1'b1; start = 1'b1;
        step(1);
        start = 1'b0;
        check("cont_busy", 32'(busy), 32'd1);
        check("cont_v0",   32'(sample_valid), 32'd0);
        step(1);
        check("cont_v1",   32'(sample_valid), 32'd0);
        step(1);
        check("cont_v2",   32'(sample_valid), 32'd1);
        check("cont_d2",   32'(sample_data), 32'd1);
        check("cont_sel2", 32'(sel), 32'd0);
        check("cont_busy2", 32'(busy), 32'd1);
        in_vec = 4'b1110;
        step(1);
        check("cont_v3",   32'(sample_valid), 32'd0);
        check("cont_d3",   32'(sample_data), 32'd1);
        step(1);
        check("cont_v4",   32'(sample_valid), 32'd1);
        check("cont_d4",   32'(sample_data), 32'd0);
        in_vec = 4'b0001;
        step(2);
        check("cont_v6",   32'(sample_valid), 32'd1);
        check("cont_d6",   32'(sample_data), 32'd1);
        check("cont_sel6", 32'(sel), 32'd0);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("cont_stop_busy", 32'(busy), 32'd0);
        check("cont_stop_val",  32'(sample_valid), 32'd0);
        cont = 1'b0;

        // Abort mid-scan: data must keep the last completed frame.
        in_vec = 4'hE; en_mask = 4'hF; dwell = 8'd3; start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        check("abort_busy_pre", 32'(busy), 32'd1);
        check("abort_sel_pre",  32'(sel), 32'd1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sel",  32'(sel), 32'd0);
        for (int k = 0; k < 12; k++) begin
            check("abort_no_valid", 32'(sample_valid), 32'd0);
            step(1);
        end
        check("abort_data", 32'(sample_data), 32'd1);

        // Stop coinciding with the end of a one-channel frame.
        in_vec = 4'h0; en_mask = 4'b0001; dwell = 8'd0; start = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("stop_eof_valid", 32'(sample_valid), 32'd0);
        check("stop_eof_busy",  32'(busy), 32'd0);
        check("stop_eof_data",  32'(sample_data), 32'd1);

        // Ignored starts.
        en_mask = 4'h0; start = 1'b1;
        step(2);
        check("empty_mask_busy", 32'(busy), 32'd0);
        check("empty_mask_sel",  32'(sel), 32'd0);
        en_mask = 4'hF; stop = 1'b1;
        step(2);
        check("start_stop_busy", 32'(busy), 32'd0);
        start = 1'b0; stop = 1'b0;
        step(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
